// File: rtl/fwd_pkg.sv
// Shared definitions for the ID/EX operand-forwarding stage: select codes,
// the hard-wired zero register and the statistics counter width.
package fwd_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_RSVD  = 2'b11
  } fwd_sel_e;

  // Register 0 reads as zero architecturally and is never a forwarding target.
  localparam int unsigned REG_ZERO = 0;

  localparam int unsigned STAT_W   = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

endpackage : fwd_pkg

// File: rtl/fwd_operand_stage_if.sv
// Bundle of the operand-forwarding stage: decode-side operands, EX/MEM and
// MEM/WB result buses in, registered ID/EX operands out.
// Optional statistics outputs appear when FWD_STATS_EN is defined.
interface fwd_operand_stage_if
  import fwd_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5,
  parameter int N_OPS   = 2,
  parameter int NB_SEL  = 2
);

  logic                       valid_i;
  logic                       stall_i;
  logic                       flush_i;
  logic [N_OPS*NB_ADDR-1:0]   src_addr_i;
  logic [N_OPS*NB_DATA-1:0]   rf_data_i;
  logic [NB_ADDR-1:0]         exmem_rd_i;
  logic                       exmem_regwrite_i;
  logic [NB_DATA-1:0]         exmem_data_i;
  logic [NB_ADDR-1:0]         memwb_rd_i;
  logic                       memwb_regwrite_i;
  logic [NB_DATA-1:0]         memwb_data_i;
  logic [N_OPS*NB_DATA-1:0]   data_o;
  logic                       valid_o;
  logic [N_OPS*NB_SEL-1:0]    fwd_sel_o;
`ifdef FWD_STATS_EN
  logic [STAT_W-1:0]          stat_exmem_o;
  logic [STAT_W-1:0]          stat_memwb_o;
`endif

  // Upstream side: drives instruction operands and the forwarding sources.
  modport master (
    output valid_i, stall_i, flush_i, src_addr_i, rf_data_i,
    output exmem_rd_i, exmem_regwrite_i, exmem_data_i,
    output memwb_rd_i, memwb_regwrite_i, memwb_data_i,
`ifdef FWD_STATS_EN
    input  stat_exmem_o, stat_memwb_o,
`endif
    input  data_o, valid_o, fwd_sel_o
  );

  // The stage itself.
  modport slave (
    input  valid_i, stall_i, flush_i, src_addr_i, rf_data_i,
    input  exmem_rd_i, exmem_regwrite_i, exmem_data_i,
    input  memwb_rd_i, memwb_regwrite_i, memwb_data_i,
`ifdef FWD_STATS_EN
    output stat_exmem_o, stat_memwb_o,
`endif
    output data_o, valid_o, fwd_sel_o
  );

endinterface : fwd_operand_stage_if

// File: rtl/fwd_sel_unit.sv
// Per-channel forwarding select: compares one source register against the
// EX/MEM and MEM/WB destinations and picks the freshest value.
// EX/MEM beats MEM/WB; register 0 always comes from the register file.
module fwd_sel_unit
  import fwd_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_SEL  = 2
) (
  input  logic [NB_ADDR-1:0] src_addr_i,
  input  logic [NB_DATA-1:0] rf_data_i,
  input  logic [NB_ADDR-1:0] exmem_rd_i,
  input  logic               exmem_regwrite_i,
  input  logic [NB_DATA-1:0] exmem_data_i,
  input  logic [NB_ADDR-1:0] memwb_rd_i,
  input  logic               memwb_regwrite_i,
  input  logic [NB_DATA-1:0] memwb_data_i,
  output logic [NB_SEL-1:0]  sel_o,
  output logic [NB_DATA-1:0] data_o
);

  logic     src_nonzero;
  logic     exmem_hit;
  logic     memwb_hit;
  fwd_sel_e sel;

  assign src_nonzero = (src_addr_i != NB_ADDR'(REG_ZERO));
  assign exmem_hit   = exmem_regwrite_i && (exmem_rd_i == src_addr_i) && src_nonzero;
  assign memwb_hit   = memwb_regwrite_i && (memwb_rd_i == src_addr_i) && src_nonzero;

  // Priority select: the younger EX/MEM result shadows the older MEM/WB one.
  always_comb begin
    // NOTE: default first so every path assigns sel; otherwise a latch is inferred.
    sel = FWD_RF;
    if (exmem_hit) begin
      sel = FWD_EXMEM;
    end else if (memwb_hit) begin
      sel = FWD_MEMWB;
    end
  end

  // Operand mux; the reserved code falls back to register-file data.
  always_comb begin
    data_o = rf_data_i;
    case (sel)
      FWD_EXMEM:      data_o = exmem_data_i;
      FWD_MEMWB:      data_o = memwb_data_i;
      FWD_RF, FWD_RSVD: data_o = rf_data_i;
      default:        data_o = rf_data_i;
    endcase
  end

  assign sel_o = NB_SEL'(sel);

endmodule : fwd_sel_unit

// File: rtl/fwd_operand_stage.sv
// N-channel operand-forwarding stage at the ID/EX boundary: one select unit
// per operand feeds the ID/EX latch, which obeys flush > stall > update.
// Define FWD_STATS_EN to add saturating EX/MEM and MEM/WB usage counters.
module fwd_operand_stage
  import fwd_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5,
  parameter int N_OPS   = 2,
  parameter int NB_SEL  = 2
) (
  input  logic          clock_i,
  input  logic          reset_i,
  fwd_operand_stage_if.slave bus
);

  logic [N_OPS*NB_DATA-1:0] data_d;
  logic [N_OPS*NB_SEL-1:0]  sel_d;

  logic [N_OPS*NB_DATA-1:0] data_q;
  logic [N_OPS*NB_SEL-1:0]  sel_q;
  logic                     valid_q;

  for (genvar k = 0; k < N_OPS; k++) begin : g_chan
    fwd_sel_unit #(
      .NB_DATA (NB_DATA),
      .NB_ADDR (NB_ADDR),
      .NB_SEL  (NB_SEL)
    ) u_sel (
      .src_addr_i       (bus.src_addr_i[k*NB_ADDR +: NB_ADDR]),
      .rf_data_i        (bus.rf_data_i[k*NB_DATA +: NB_DATA]),
      .exmem_rd_i       (bus.exmem_rd_i),
      .exmem_regwrite_i (bus.exmem_regwrite_i),
      .exmem_data_i     (bus.exmem_data_i),
      .memwb_rd_i       (bus.memwb_rd_i),
      .memwb_regwrite_i (bus.memwb_regwrite_i),
      .memwb_data_i     (bus.memwb_data_i),
      .sel_o            (sel_d[k*NB_SEL +: NB_SEL]),
      .data_o           (data_d[k*NB_DATA +: NB_DATA])
    );
  end

  // ID/EX latch: flush clears to a bubble, stall holds, otherwise capture.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else if (bus.flush_i) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else if (!bus.stall_i) begin
      // NOTE: non-blocking so every register samples pre-edge values.
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= bus.valid_i;
    end
  end

  assign bus.data_o    = data_q;
  assign bus.fwd_sel_o = sel_q;
  assign bus.valid_o   = valid_q;

`ifdef FWD_STATS_EN
  logic              any_exmem;
  logic              any_memwb;
  logic              update_en;
  logic [STAT_W-1:0] stat_exmem_q;
  logic [STAT_W-1:0] stat_memwb_q;

  // Does any channel draw from each forwarding source this cycle?
  always_comb begin
    any_exmem = 1'b0;
    any_memwb = 1'b0;
    for (int k = 0; k < N_OPS; k++) begin
      if (sel_d[k*NB_SEL +: NB_SEL] == NB_SEL'(FWD_EXMEM)) any_exmem = 1'b1;
      if (sel_d[k*NB_SEL +: NB_SEL] == NB_SEL'(FWD_MEMWB)) any_memwb = 1'b1;
    end
  end

  // Only real instructions that actually enter EX are counted.
  assign update_en = bus.valid_i && !bus.stall_i && !bus.flush_i;

  // Saturating usage counters.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      stat_exmem_q <= '0;
      stat_memwb_q <= '0;
    end else if (update_en) begin
      if (any_exmem && (stat_exmem_q != STAT_MAX)) stat_exmem_q <= stat_exmem_q + 1'b1;
      if (any_memwb && (stat_memwb_q != STAT_MAX)) stat_memwb_q <= stat_memwb_q + 1'b1;
    end
  end

  assign bus.stat_exmem_o = stat_exmem_q;
  assign bus.stat_memwb_o = stat_memwb_q;
`endif

endmodule : fwd_operand_stage

// File: tb/tb_fwd_operand_stage.sv
// Scoreboard bench for fwd_operand_stage: stimulus pushes the expected latch
// contents from a behavioural model; a monitor compares after every edge.
// Define FWD_STATS_EN to also check the statistics counters.
module tb_fwd_operand_stage;
  import fwd_pkg::*;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 5;
  localparam int N_OPS   = 2;
  localparam int NB_SEL  = 2;

  typedef struct {
    logic [N_OPS*NB_DATA-1:0] data;
    logic [N_OPS*NB_SEL-1:0]  sel;
    logic                     valid;
    logic [15:0]              st_ex;
    logic [15:0]              st_mw;
    string                    tag;
  } exp_t;

  logic clock_i = 1'b0;
  logic reset_i = 1'b1;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  // Reference state: what the ID/EX latch should hold.
  logic [NB_DATA-1:0] m_data [N_OPS];
  logic [1:0]         m_sel  [N_OPS];
  logic               m_valid;
  int                 m_st_ex;
  int                 m_st_mw;

  fwd_operand_stage_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .N_OPS(N_OPS), .NB_SEL(NB_SEL)) bus ();

  fwd_operand_stage #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .N_OPS(N_OPS), .NB_SEL(NB_SEL)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_OPS; k++) begin
      m_data[k] = '0;
      m_sel[k]  = 2'b00;
    end
    m_valid = 1'b0;
    m_st_ex = 0;
    m_st_mw = 0;
  endtask

  // Apply the stage's rules to the inputs currently on the bus and queue the result.
  task automatic model_step(input string tag);
    exp_t e;
    bit   hit_ex = 0;
    bit   hit_mw = 0;
    if (bus.flush_i) begin
      for (int k = 0; k < N_OPS; k++) begin
        m_data[k] = '0;
        m_sel[k]  = 2'b00;
      end
      m_valid = 1'b0;
    end else if (!bus.stall_i) begin
      for (int k = 0; k < N_OPS; k++) begin
        int unsigned a;
        a = bus.src_addr_i[k*NB_ADDR +: NB_ADDR];
        if (a != 0 && bus.exmem_regwrite_i && bus.exmem_rd_i == a) begin
          m_data[k] = bus.exmem_data_i;
          m_sel[k]  = 2'b01;
          hit_ex    = 1;
        end else if (a != 0 && bus.memwb_regwrite_i && bus.memwb_rd_i == a) begin
          m_data[k] = bus.memwb_data_i;
          m_sel[k]  = 2'b10;
          hit_mw    = 1;
        end else begin
          m_data[k] = bus.rf_data_i[k*NB_DATA +: NB_DATA];
          m_sel[k]  = 2'b00;
        end
      end
      m_valid = bus.valid_i;
      if (bus.valid_i && hit_ex && m_st_ex < 65535) m_st_ex++;
      if (bus.valid_i && hit_mw && m_st_mw < 65535) m_st_mw++;
    end
    for (int k = 0; k < N_OPS; k++) begin
      e.data[k*NB_DATA +: NB_DATA] = m_data[k];
      e.sel[k*NB_SEL +: NB_SEL]    = m_sel[k];
    end
    e.valid = m_valid;
    e.st_ex = 16'(m_st_ex);
    e.st_mw = 16'(m_st_mw);
    e.tag   = tag;
    sb.push_back(e);
  endtask

  // Called at a falling edge: drive one cycle of inputs, log expectation, move on.
  task automatic drive(input string tag, input logic v, input logic st, input logic fl,
                       input logic [NB_ADDR-1:0] s0, input logic [NB_ADDR-1:0] s1,
                       input logic [NB_DATA-1:0] r0, input logic [NB_DATA-1:0] r1,
                       input logic [NB_ADDR-1:0] exrd, input logic exrw, input logic [NB_DATA-1:0] exd,
                       input logic [NB_ADDR-1:0] mwrd, input logic mwrw, input logic [NB_DATA-1:0] mwd);
    bus.valid_i          = v;
    bus.stall_i          = st;
    bus.flush_i          = fl;
    bus.src_addr_i       = {s1, s0};
    bus.rf_data_i        = {r1, r0};
    bus.exmem_rd_i       = exrd;
    bus.exmem_regwrite_i = exrw;
    bus.exmem_data_i     = exd;
    bus.memwb_rd_i       = mwrd;
    bus.memwb_regwrite_i = mwrw;
    bus.memwb_data_i     = mwd;
    model_step(tag);
    @(negedge clock_i);
  endtask

  task automatic drive_random(input string tag, input int stall_pct, input int flush_pct);
    drive(tag, 1'($urandom), ($urandom_range(99) < stall_pct), ($urandom_range(99) < flush_pct),
          5'($urandom_range(7)), 5'($urandom_range(7)), $urandom, $urandom,
          5'($urandom_range(7)), 1'($urandom), $urandom,
          5'($urandom_range(7)), 1'($urandom), $urandom);
  endtask

  // Monitor: after each edge the latch has settled; compare with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock_i);
      #1;
      if (!reset_i && sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, " data"},  128'(bus.data_o),    128'(e.data));
        check({e.tag, " sel"},   128'(bus.fwd_sel_o), 128'(e.sel));
        check({e.tag, " valid"}, 128'(bus.valid_o),   128'(e.valid));
`ifdef FWD_STATS_EN
        check({e.tag, " st_ex"}, 128'(bus.stat_exmem_o), 128'(e.st_ex));
        check({e.tag, " st_mw"}, 128'(bus.stat_memwb_o), 128'(e.st_mw));
`endif
      end
    end
  end

  task automatic async_reset_check(input string tag);
    #2 reset_i = 1'b1;
    #1;
    check({tag, " rst data"},  128'(bus.data_o),    128'(0));
    check({tag, " rst valid"}, 128'(bus.valid_o),   128'(0));
    check({tag, " rst sel"},   128'(bus.fwd_sel_o), 128'(0));
`ifdef FWD_STATS_EN
    check({tag, " rst st_ex"}, 128'(bus.stat_exmem_o), 128'(0));
`endif
    model_reset();
    @(negedge clock_i);
    reset_i = 1'b0;
  endtask

  initial begin
    model_reset();
    bus.valid_i = 0; bus.stall_i = 0; bus.flush_i = 0;
    bus.src_addr_i = '0; bus.rf_data_i = '0;
    bus.exmem_rd_i = '0; bus.exmem_regwrite_i = 0; bus.exmem_data_i = '0;
    bus.memwb_rd_i = '0; bus.memwb_regwrite_i = 0; bus.memwb_data_i = '0;
    #1;
    check("por data",  128'(bus.data_o),    128'(0));
    check("por valid", 128'(bus.valid_o),   128'(0));
    check("por sel",   128'(bus.fwd_sel_o), 128'(0));
    @(negedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b0;

    // EX/MEM wins over MEM/WB on the same register.
    drive("exmem_prio", 1, 0, 0, 5, 0, 32'h0, 32'h0, 5, 1, 32'hAAAA0001, 5, 1, 32'hBBBB0002);
    // MEM/WB used when EX/MEM does not write.
    drive("memwb_path", 1, 0, 0, 1, 7, 32'h1, 32'h7777, 7, 0, 32'h9, 7, 1, 32'h12345678);
    // Neither writes: register file.
    drive("rf_path",    1, 0, 0, 1, 7, 32'h1, 32'h7777, 7, 0, 32'h9, 7, 0, 32'h12345678);
    // Register zero is never forwarded.
    drive("reg_zero",   1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 32'hDEADBEEF, 0, 1, 32'hCAFEF00D);
    // Bubble: data captured, valid low.
    drive("bubble",     0, 0, 0, 3, 4, 32'h33, 32'h44, 4, 1, 32'h4444, 9, 0, 32'h0);

    // Capture 0x11, hold through three stalls with changing inputs, then flush+stall.
    drive("cap11", 1, 0, 0, 1, 2, 32'h11, 32'h22, 9, 0, 32'h0, 9, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive("stall_hold", 0, 1, 0, 5'($urandom_range(7)), 5'($urandom_range(7)), $urandom, $urandom,
            5'($urandom_range(7)), 1, $urandom, 5'($urandom_range(7)), 1, $urandom);
      check("stall_data0", 128'(bus.data_o[NB_DATA-1:0]), 128'(32'h11));
    end
    drive("flush_over_stall", 1, 1, 1, 1, 2, 32'h55, 32'h66, 1, 1, 32'h77, 2, 1, 32'h88);

    // Random traffic, then reset asynchronously while valid_o is high.
    for (int i = 0; i < 300; i++) drive_random("rand_a", 20, 8);
    drive("pre_rst", 1, 0, 0, 2, 3, 32'hA5A5A5A5, 32'h5A5A5A5A, 2, 1, 32'hF00DF00D, 3, 1, 32'hBEEF);
    async_reset_check("midstream");
    for (int i = 0; i < 300; i++) drive_random("rand_b", 15, 5);

`ifdef FWD_STATS_EN
    // Ten valid EX/MEM-matching instructions, two of them stalled.
    async_reset_check("stats");
    for (int i = 0; i < 10; i++)
      drive("stat_cnt", 1, (i == 3 || i == 7), 0, 3, 0, $urandom, $urandom, 3, 1, $urandom, 0, 0, 0);
    check("stat_exmem_8", 128'(bus.stat_exmem_o), 128'(8));
    for (int i = 0; i < 65540; i++)
      drive("stat_sat", 1, 0, 0, 3, 0, 0, 0, 3, 1, 32'h1, 0, 0, 0);
    check("stat_exmem_sat", 128'(bus.stat_exmem_o), 128'(16'hFFFF));
`endif

    drive("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock_i);
    check("sb_drained", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fwd_operand_stage

// File: doc/fwd_operand_stage.md
Name: fwd_operand_stage

Overview:
N-channel operand-forwarding stage for the MIPS ID/EX boundary. Each channel has its own select logic:
- compares its source register address against the EX/MEM and MEM/WB destinations;
- picks register-file, EX/MEM or MEM/WB data;
- registers the result into the pipeline latch, with stall and flush control.

It replaces the standalone combinational forwarding muxes and the separate ID/EX operand latch.

Parameters:
NB_DATA, 32, operand data width
NB_ADDR, 5, register address width
N_OPS, 2, number of operand channels (rs, rt, ...)
NB_SEL, 2, select code width per channel

Ports:
clock_i  in  1  system clock, rising edge
reset_i  in  1  asynchronous, active-high reset
valid_i  in  1  incoming instruction valid
stall_i  in  1  hold latch contents
flush_i  in  1  insert bubble
src_addr_i  in  N_OPS*NB_ADDR  source register address per channel (channel k at bits [k*NB_ADDR +: NB_ADDR])
rf_data_i  in  N_OPS*NB_DATA  register-file read data per channel
exmem_rd_i  in  NB_ADDR  EX/MEM destination register
exmem_regwrite_i  in  1  EX/MEM writes register
exmem_data_i  in  NB_DATA  EX/MEM ALU result
memwb_rd_i  in  NB_ADDR  MEM/WB destination register
memwb_regwrite_i  in  1  MEM/WB writes register
memwb_data_i  in  NB_DATA  MEM/WB write-back data
data_o  out  N_OPS*NB_DATA  registered operands
valid_o  out  1  registered valid
fwd_sel_o  out  N_OPS*NB_SEL  registered select code per channel (debug/trace)

Behaviour:
- Reset (async, any time including mid-stall): data_o=0, valid_o=0, fwd_sel_o=0 (all channels FWD_RF). Counters, if present, clear to 0.
- Select per channel k, combinational:
  - FWD_EXMEM (2'b01) if exmem_regwrite_i && exmem_rd_i==src_addr[k] && src_addr[k]!=0;
  - else FWD_MEMWB (2'b10) if the same condition holds for memwb;
  - else FWD_RF (2'b00).
  - EX/MEM always wins over MEM/WB when both match.
  - Register 0 is never forwarded; it always reads rf_data.
- Code 2'b11 is reserved and selects rf_data.
- Latency: 1 cycle. Values present at rising edge N appear on data_o after edge N.
- Each rising edge, priority order:
  1. flush_i=1: valid_o<=0, data_o<=0, fwd_sel_o<=0. Flush beats a simultaneous stall.
  2. stall_i=1: all outputs hold their previous values. Forwarding inputs are ignored that cycle.
  3. Otherwise: data_o<=selected data, fwd_sel_o<=select, valid_o<=valid_i.
- With valid_i=0 and no stall/flush, data is still captured, but valid_o=0 marks it a bubble.
- Width rule: all data paths are full NB_DATA. No extension or truncation.
- Forwarding of a load result still in EX/MEM is not resolved here. The hazard unit must stall.

Optional Feature:
Macro FWD_STATS_EN.
- Defined:
  - adds outputs stat_exmem_o[15:0] and stat_memwb_o[15:0];
  - each counts updating edges (no stall, no flush, valid_i=1) on which at least one channel selects that source;
  - counters saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- Package fwd_pkg holds:
  - select codes FWD_RF, FWD_EXMEM, FWD_MEMWB, FWD_RSVD;
  - the reg-zero constant;
  - the stat counter width (16).
- Sub-module fwd_sel_unit (one instance per channel via generate) does the address compare and priority. It outputs the NB_SEL select and the selected NB_DATA word.
- The top level holds the pipeline registers, stall/flush priority and optional counters.

Test Plan:
- Reset mid-stream: assert reset_i asynchronously between edges while valid_o=1 -> data_o, valid_o and fwd_sel_o read 0 immediately.
- EX/MEM priority: src_addr[0]=5, exmem_rd=5/regwrite=1/data=0xAAAA0001, memwb_rd=5/regwrite=1/data=0xBBBB0002 -> next cycle data_o[0]=0xAAAA0001, fwd_sel[0]=01.
- MEM/WB and register-file paths: src_addr[1]=7, exmem_rd=7/regwrite=0, memwb_rd=7/regwrite=1/data=0x12345678 -> data_o[1]=0x12345678, fwd_sel=10. Same case with memwb_regwrite=0 -> rf_data[1], fwd_sel=00.
- Register zero: src_addr=0, exmem_rd=0/regwrite=1/data=0xDEADBEEF, rf_data=0 -> data_o=0, fwd_sel=00.
- Stall then flush:
  - capture 0x11 with valid_i=1;
  - 3 cycles stall_i=1 with changing inputs -> data_o stays 0x11, valid_o=1;
  - then flush_i=1 together with stall_i=1 -> valid_o=0, data_o=0.
- FWD_STATS_EN: 10 valid updates with exmem matches, 2 of them stalled -> stat_exmem_o=8. Preload near saturation -> holds at 0xFFFF.
